// File: rtl/div_seq32_if.sv
// div_seq32_if: start/operand/result bundle for the sequential 32-bit signed divider.
//   ctrl_div        start pulse (master -> divider)
//   data_operandA   dividend, two's complement (master -> divider)
//   data_operandB   divisor, two's complement (master -> divider)
//   data_result     truncated quotient, held until the next accepted start (divider -> master)
//   data_exception  divide-by-zero / overflow flag (divider -> master)
//   data_resultRDY  one-cycle completion strobe (divider -> master)
//   busy            operation in flight (divider -> master)
interface div_seq32_if;
  logic        ctrl_div;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  modport master (
    output ctrl_div, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_div, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/div_seq32.sv
// div_seq32: sequential 32-bit signed restoring divider (truncating quotient).
//   clk  rising-edge clock
//   clr  synchronous active-high reset
//   bus  div_seq32_if.slave: ctrl_div start pulse, data_operandA/B operands in;
//        data_result, data_exception, data_resultRDY strobe and busy out.
// A start in IDLE latches magnitudes, then 32 RUN cycles produce one quotient bit each,
// FIX applies the sign, and DONE raises the registered ready strobe on the next edge.
module div_seq32 (
  input logic        clk,
  input logic        clr,
  div_seq32_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] rq_q, rq_d;        // {remainder, quotient/dividend}
  logic [31:0] abs_b_q, abs_b_d;
  logic        sign_q, sign_d;
  logic        ovf_q, ovf_d;      // 0x80000000 / -1 case
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        rdy_q, rdy_d;

  logic [31:0] abs_a;
  logic [31:0] quo_sh;
  logic [32:0] trial;

  always_comb begin
    // Negation wraps 0x80000000 to itself, which is its correct unsigned magnitude.
    abs_a  = bus.data_operandA[31] ? (32'd0 - bus.data_operandA) : bus.data_operandA;
    quo_sh = {rq_q[30:0], 1'b0};
    // Shifted remainder is rq_q[63:31]; bit 63 stays 0, so 33 bits never overflow.
    trial  = rq_q[63:31] - {1'b0, abs_b_q};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rq_d     = rq_q;
    abs_b_d  = abs_b_q;
    sign_d   = sign_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.ctrl_div) begin
          abs_b_d = bus.data_operandB[31] ? (32'd0 - bus.data_operandB) : bus.data_operandB;
          sign_d  = bus.data_operandA[31] ^ bus.data_operandB[31];
          ovf_d   = (bus.data_operandA == 32'h8000_0000) && (bus.data_operandB == 32'hFFFF_FFFF);
          rq_d    = {32'd0, abs_a};
          cnt_d   = 6'd0;
          if (bus.data_operandB == 32'd0) begin
            result_d = 32'd0;
            exc_d    = 1'b1;
            state_d  = StDone;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (trial[32]) begin
          rq_d = {rq_q[62:31], quo_sh};
        end else begin
          rq_d = {trial[31:0], quo_sh | 32'd1};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = StFix;
        end
      end
      StFix: begin
        // Overflow case needs no special value: -0x80000000 wraps to 0x80000000.
        result_d = sign_q ? (32'd0 - rq_q[31:0]) : rq_q[31:0];
        exc_d    = ovf_q;
        state_d  = StDone;
      end
      StDone: begin
        rdy_d   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= StIdle;
      cnt_q    <= 6'd0;
      rq_q     <= 64'd0;
      abs_b_q  <= 32'd0;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rq_q     <= rq_d;
      abs_b_q  <= abs_b_d;
      sign_q   <= sign_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  // Busy through DONE; drops on the same edge the registered strobe rises.
  assign bus.busy           = (state_q != StIdle);

endmodule

// File: tb/tb_div_seq32.sv
// tb_div_seq32: randomized and directed bench for div_seq32 against an arithmetic model.
module tb_div_seq32;

  logic clk;
  logic clr;
  div_seq32_if bus ();

  div_seq32 dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] prev_res;
  logic        prev_exc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic e);
    if (b == 32'd0) begin
      q = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      e = 1'b1;
    end else begin
      q = $signed(a) / $signed(b);
      e = 1'b0;
    end
  endfunction

  // Called at a negedge with the block in IDLE; returns at the negedge where the strobe
  // is seen, so a following call starts on the earliest legal edge.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input int inj);
    logic [31:0] er;
    logic        ee;
    int          k;
    int          lat_exp;
    model(a, b, er, ee);
    lat_exp = (b == 32'd0) ? 1 : 34;
    bus.ctrl_div      = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clk);
    #1;
    bus.ctrl_div      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
    @(negedge clk);
    k = 0;
    check("busy_start", 32'(bus.busy), 32'd1);
    check("rdy_after_start", 32'(bus.data_resultRDY), 32'd0);
    while (!bus.data_resultRDY && k < 100) begin
      if (k == inj) begin
        bus.ctrl_div      = 1'b1;
        bus.data_operandA = 32'd9;
        bus.data_operandB = 32'd3;
      end else begin
        bus.ctrl_div = 1'b0;
      end
      @(posedge clk);
      #1;
      bus.ctrl_div = 1'b0;
      k++;
      @(negedge clk);
      if (k == 20) begin
        check("hold_result", bus.data_result, prev_res);
        check("hold_exc", 32'(bus.data_exception), 32'(prev_exc));
      end
    end
    check("latency", 32'(k), 32'(lat_exp));
    check("result", bus.data_result, er);
    check("exception", 32'(bus.data_exception), 32'(ee));
    check("busy_at_rdy", 32'(bus.busy), 32'd0);
    prev_res = er;
    prev_exc = ee;
  endtask

  initial begin
    logic [31:0] a, b;
    int          nrdy;

    clr               = 1'b1;
    bus.ctrl_div      = 1'b0;
    bus.data_operandA = 32'd0;
    bus.data_operandB = 32'd0;
    prev_res          = 32'd0;
    prev_exc          = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    check("rst_result", bus.data_result, 32'd0);
    check("rst_exc", 32'(bus.data_exception), 32'd0);
    check("rst_rdy", 32'(bus.data_resultRDY), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    // Directed cases, chained back to back.
    do_div(32'd100, 32'd7, -1);
    do_div(32'hFFFF_FF9C, 32'd7, -1);
    do_div(32'd100, 32'hFFFF_FFF9, -1);
    do_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, -1);
    do_div(32'd7, 32'd0, -1);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, -1);
    do_div(32'h8000_0000, 32'd2, -1);
    do_div(32'h7FFF_FFFF, 32'h8000_0000, -1);
    do_div(32'h8000_0000, 32'h8000_0000, -1);

    // Start ignored mid-run (sampled at cycle 10), then 9/3 on the following IDLE edge.
    do_div(32'd100, 32'd7, 9);
    do_div(32'd9, 32'd3, -1);

    // Randomized operands with a bias toward corner divisors.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(0, 40)) - 32'd20;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      do_div(a, b, -1);
    end

    // Abort with clr at cycle 15; a coincident ctrl_div must lose to clr.
    @(negedge clk);
    bus.ctrl_div      = 1'b1;
    bus.data_operandA = 32'd100;
    bus.data_operandB = 32'd7;
    @(posedge clk);
    #1;
    bus.ctrl_div = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    clr               = 1'b1;
    bus.ctrl_div      = 1'b1;
    bus.data_operandA = 32'd5;
    bus.data_operandB = 32'd1;
    @(posedge clk);
    #1;
    clr          = 1'b0;
    bus.ctrl_div = 1'b0;
    @(negedge clk);
    check("clr_result", bus.data_result, 32'd0);
    check("clr_exc", 32'(bus.data_exception), 32'd0);
    check("clr_rdy", 32'(bus.data_resultRDY), 32'd0);
    check("clr_busy", 32'(bus.busy), 32'd0);
    nrdy = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.data_resultRDY) nrdy++;
    end
    check("clr_no_strobe", 32'(nrdy), 32'd0);
    prev_res = 32'd0;
    prev_exc = 1'b0;
    do_div(32'd50, 32'd5, -1);

    @(negedge clk);
    check("final_rdy_drop", 32'(bus.data_resultRDY), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
